// File: rtl/intersection_ctrl.sv
// Two-approach (NS/EW) intersection controller with all-red clearance, latched
// pedestrian walk phase and a night-mode flashing-yellow state, paced by en.
module intersection_ctrl #(
  parameter int CNT_W         = 8,
  parameter int GREEN_TICKS   = 8,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 2,
  parameter int WALK_TICKS    = 6,
  parameter int FLASH_TICKS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       ped_walk,
  output logic       ped_pending,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RED_NS    = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_EW    = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    WALK      = 3'd6,
    FLASH     = 3'd7
  } state_e;

  typedef struct packed {
    logic ns_red;
    logic ns_yellow;
    logic ns_green;
    logic ew_red;
    logic ew_yellow;
    logic ew_green;
    logic ped_walk;
  } lamps_t;

  // Terminal timer values: a phase of D ticks ends when the timer reads D-1.
  localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LAST    = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(FLASH_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             flash_q, flash_d;
  logic             pend_q, pend_d;
  lamps_t           lamps_q;

  function automatic logic [CNT_W-1:0] last_tick(input state_e s);
    case (s)
      RED_NS, RED_EW:       last_tick = ALL_RED_LAST;
      NS_GREEN, EW_GREEN:   last_tick = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: last_tick = YELLOW_LAST;
      WALK:                 last_tick = WALK_LAST;
      default:              last_tick = FLASH_LAST;
    endcase
  endfunction

  function automatic lamps_t decode(input state_e s, input logic fl);
    lamps_t l;
    l = '0;
    case (s)
      RED_NS, RED_EW: begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
      NS_GREEN:       begin l.ns_green = 1'b1; l.ew_red = 1'b1; end
      NS_YELLOW:      begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
      EW_GREEN:       begin l.ew_green = 1'b1; l.ns_red = 1'b1; end
      EW_YELLOW:      begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
      WALK:           begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.ped_walk = 1'b1; end
      default:        begin l.ns_yellow = fl; l.ew_yellow = fl; end
    endcase
    return l;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d = state_q;
    timer_d = timer_q;
    flash_d = flash_q;
    pend_d  = pend_q | ped_req;

    if (en) begin
      if (state_q == FLASH) begin
        if (!night_mode) begin
          state_d = RED_NS;
          timer_d = '0;
          flash_d = 1'b0;
        end else if (timer_q == FLASH_LAST) begin
          timer_d = '0;
          flash_d = ~flash_q;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end else if (timer_q == last_tick(state_q)) begin
        timer_d = '0;
        unique case (state_q)
          RED_NS: begin
            if (night_mode) begin
              state_d = FLASH;
              flash_d = 1'b1;
            end else if (pend_q) begin
              state_d = WALK;
            end else begin
              state_d = NS_GREEN;
            end
          end
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: state_d = RED_EW;
          RED_EW: begin
            if (night_mode) begin
              state_d = FLASH;
              flash_d = 1'b1;
            end else begin
              state_d = EW_GREEN;
            end
          end
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: state_d = RED_NS;
          WALK:      state_d = NS_GREEN;
          default:   state_d = RED_NS;
        endcase
      end else begin
        timer_d = timer_q + CNT_W'(1);
      end
    end

    // Entering WALK serves the request; a request arriving on that same cycle survives.
    if (state_d == WALK && state_q != WALK) pend_d = ped_req;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= RED_NS;
      timer_q <= '0;
      flash_q <= 1'b0;
      pend_q  <= 1'b0;
      lamps_q <= decode(RED_NS, 1'b0);
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flash_q <= flash_d;
      pend_q  <= pend_d;
      lamps_q <= decode(state_d, flash_d);
    end
  end

  assign ns_red      = lamps_q.ns_red;
  assign ns_yellow   = lamps_q.ns_yellow;
  assign ns_green    = lamps_q.ns_green;
  assign ew_red      = lamps_q.ew_red;
  assign ew_yellow   = lamps_q.ew_yellow;
  assign ew_green    = lamps_q.ew_green;
  assign ped_walk    = lamps_q.ped_walk;
  assign ped_pending = pend_q;
  assign state       = state_q;

endmodule
